// File: rtl/generate_serializer.sv
// ============================================================================
// generate_serializer
//   Parallel-in, serial-out transmitter. A BITS-wide word is taken over a
//   valid/ready handshake and shifted out LSB-first, one bit per clock, with
//   frame_start on bit 0 and done on bit BITS-1. Back-to-back frames are
//   supported by accepting the next word on the last bit of the current one.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   data_in      in   [BITS-1:0] parallel word to transmit
//   load_valid   in   data_in is valid this cycle
//   load_ready   out  word is accepted at this edge when load_valid is high
//   serial_out   out  current serial bit (LSB first), 0 when idle
//   serial_valid out  serial_out carries a frame bit
//   frame_start  out  first bit (bit 0) of a frame
//   done         out  last bit (bit BITS-1) of a frame
//
// The serial outputs and load_ready are combinational decodes of the state,
// bit counter and shift register LSB, so bit 0 of a word accepted at edge k
// appears in the cycle right after edge k.
// ============================================================================
`timescale 1ns/1ps

module generate_serializer #(
    parameter int unsigned BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] data_in,
    input  logic            load_valid,
    output logic            load_ready,
    output logic            serial_out,
    output logic            serial_valid,
    output logic            frame_start,
    output logic            done
);

    localparam int unsigned   CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [BITS-1:0]    r_shreg;
    logic               w_accept;
    logic               w_shifting;

    // State and bit-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_accept     = 1'b0;
        load_ready   = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                w_accept   = load_valid;
                if (load_valid) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = '0;
                end
            end

            SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = r_shreg[0];
                frame_start  = (r_count == '0);
                done         = (r_count == LAST);
                // Ready only on the last bit so the next frame follows gaplessly
                load_ready   = (r_count == LAST);
                w_accept     = load_valid && (r_count == LAST);
                if (r_count == LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = (load_valid) ? SHIFT : IDLE;
                end else begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign w_shifting = (r_state == SHIFT);

    // Shift register: one flop process per bit; a load wins over a shift
    for (genvar i = 0; i < int'(BITS); i++) begin : g_bit
        if (i < int'(BITS) - 1) begin : g_inner
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shreg[i] <= 1'b0;
                end else if (w_accept) begin
                    r_shreg[i] <= data_in[i];
                end else if (w_shifting) begin
                    r_shreg[i] <= r_shreg[i+1];
                end
            end
        end else begin : g_msb
            // MSB fills with zero as the word drains toward bit 0
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shreg[i] <= 1'b0;
                end else if (w_accept) begin
                    r_shreg[i] <= data_in[i];
                end else if (w_shifting) begin
                    r_shreg[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_generate_serializer.sv
// ============================================================================
// tb_generate_serializer
//   Scoreboard bench for generate_serializer (BITS=4). Accepted words push
//   their expected bit stream and word into queues; a negedge monitor pops
//   and compares every valid serial bit, reassembles words, and checks the
//   idle outputs and the invariants each cycle.
// ============================================================================
`timescale 1ns/1ps

module tb_generate_serializer;

    localparam int unsigned BITS = 4;

    typedef struct packed {
        logic b;
        logic fs;
        logic dn;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [BITS-1:0] data_in;
    logic            load_valid;
    logic            load_ready;
    logic            serial_out;
    logic            serial_valid;
    logic            frame_start;
    logic            done;

    exp_t            exp_q[$];
    logic [BITS-1:0] word_q[$];

    int              n_tests = 0;
    int              n_fail  = 0;
    logic            mon_en  = 1'b0;

    exp_t            m_e;
    logic [BITS-1:0] m_word;
    int              m_cnt = 0;

    generate_serializer #(.BITS(BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [BITS-1:0] d);
        exp_t e;
        for (int j = 0; j < int'(BITS); j++) begin
            e.b  = d[j];
            e.fs = (j == 0);
            e.dn = (j == int'(BITS) - 1);
            exp_q.push_back(e);
        end
        word_q.push_back(d);
    endtask

    // Presents a word and holds load_valid until it is accepted; returns
    // #1 after the accepting edge with load_valid still high.
    task automatic send_word(input logic [BITS-1:0] d);
        logic rdy;
        bit   ok;
        ok         = 1'b0;
        data_in    = d;
        load_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            rdy = load_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                push_word(d);
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted within 20 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: scoreboard pop, reassembly and per-cycle invariants
    always @(negedge clk) begin
        if (mon_en) begin
            if (serial_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_bit: got bit %0b with empty scoreboard at %0t",
                             serial_out, $time);
                end else begin
                    m_e = exp_q.pop_front();
                    check("serial_bit{out,fs,done}", {29'd0, serial_out, frame_start, done},
                          {29'd0, m_e.b, m_e.fs, m_e.dn});
                end
                if (frame_start) m_cnt = 0;
                if (m_cnt < int'(BITS)) m_word[m_cnt[1:0]] = serial_out;
                m_cnt++;
                if (done) begin
                    if (word_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL roundtrip: got word %0h with no word expected", m_word);
                    end else begin
                        check("roundtrip_word", 32'(m_word), 32'(word_q.pop_front()));
                    end
                end
            end else begin
                check("idle_outs{out,fs,done}", {29'd0, serial_out, frame_start, done}, 32'd0);
            end
            check("inv_fs_and_done", 32'(frame_start && done), 32'd0);
            check("inv_done_implies_ready", 32'(done && !load_ready), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic t1_bits [4];
        logic [BITS-1:0] w;
        int gap;
        t1_bits = '{1'b1, 1'b1, 1'b0, 1'b1};

        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;

        // Reset state
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_serial_valid", 32'(serial_valid), 32'd0);
        check("rst_serial_out", 32'(serial_out), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Single frame 4'b1011 -> 1,1,0,1
        send_word(4'b1011);
        load_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t1_serial_out", 32'(serial_out), 32'(t1_bits[c-1]));
            check("t1_serial_valid", 32'(serial_valid), 32'd1);
            check("t1_frame_start", 32'(frame_start), 32'(c == 1));
            check("t1_done", 32'(done), 32'(c == 4));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t1_after_valid", 32'(serial_valid), 32'd0);
        check("t1_after_ready", 32'(load_ready), 32'd1);
        idle(2);

        // Back-to-back: 1011 then 0110 presented through the done cycle
        send_word(4'b1011);
        data_in = 4'b0110;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("b2b_valid", 32'(serial_valid), 32'd1);
            check("b2b_ready", 32'(load_ready), 32'((c == 4) || (c == 8)));
            @(posedge clk);
            #1;
            if (c == 4) begin
                push_word(4'b0110);
                load_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_after_valid", 32'(serial_valid), 32'd0);
        idle(2);

        // Busy ignore: 0001, then 1111 offered during frame cycles 1-3
        send_word(4'b0001);
        data_in = 4'b1111;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("busy_ready_low", 32'(load_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        @(negedge clk);
        check("busy_last_ready", 32'(load_ready), 32'd1);
        check("busy_last_done", 32'(done), 32'd1);
        idle(4);
        @(negedge clk);
        check("busy_no_second_frame", 32'(serial_valid), 32'd0);
        idle(1);

        // Reset mid-frame: 1111, reset during frame cycle 2
        send_word(4'b1111);
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_pending_bits", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        void'(word_q.pop_back());
        @(negedge clk);
        check("abort_serial_valid", 32'(serial_valid), 32'd0);
        check("abort_serial_out", 32'(serial_out), 32'd0);
        check("abort_load_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        send_word(4'b0101);
        idle(6);

        // Round trip: 16 random words with random gaps (0 means back-to-back)
        for (int i = 0; i < 16; i++) begin
            w = BITS'($urandom);
            send_word(w);
            gap = int'($urandom_range(0, 3));
            if (gap > 0) idle(gap);
        end
        idle(10);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("word_queue_empty", 32'(word_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
